// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO with a registered, one-cycle
// read latency and re-presents its words as a valid/ready stream.
// A 2-entry output buffer (buf0 = head, buf1 = second) covers the read latency,
// so one word per cycle is sustained.
// Optional feature macro: FIFO_STREAM_READER_STATS_EN adds a saturating
// beats_count output. It counts accepted words and is cleared only by rst.
module fifo_stream_reader #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef FIFO_STREAM_READER_STATS_EN
    output logic [WIDTH-1:0] out_data,
    output logic [COUNT_WIDTH-1:0] beats_count
`else
    output logic [WIDTH-1:0] out_data
`endif
);

    // Reject degenerate widths at elaboration time.
    if (WIDTH < 1 || COUNT_WIDTH < 1) begin : g_param_check
        $error("fifo_stream_reader: WIDTH and COUNT_WIDTH must be at least 1");
    end

    logic [1:0]       count_reg, count_next;
    logic             inflight_reg;
    logic [WIDTH-1:0] buf0_reg, buf0_next;
    logic [WIDTH-1:0] buf1_reg, buf1_next;
    logic             valid_reg;
    logic             pop;
    logic [2:0]       occupancy;
    logic [2:0]       read_limit;

    assign out_valid = valid_reg;
    assign out_data  = buf0_reg;

    // Read issue: only read if the word is guaranteed a free slot on arrival.
    // (count + inflight - pop) < 2 is rewritten as count + inflight < 2 + pop
    // so that no subtraction can underflow.
    always_comb begin
        pop        = valid_reg && out_ready;
        occupancy  = {1'b0, count_reg} + {2'b00, inflight_reg};
        read_limit = pop ? 3'd3 : 3'd2;
        fifo_rd_en = !rst && !flush && !fifo_empty && (occupancy < read_limit);
    end

    // Buffer steering: a pop shifts buf1 forward, and an arriving word fills the
    // first slot that is free after that pop.
    always_comb begin
        count_next = count_reg;
        buf0_next  = buf0_reg;
        buf1_next  = buf1_reg;
        if (flush) begin
            // Buffered words and any word arriving this cycle are dropped.
            count_next = 2'd0;
        end else begin
            if (pop && count_reg == 2'd2) begin
                buf0_next = buf1_reg;
            end
            if (inflight_reg) begin
                if (count_reg == 2'd0 || (count_reg == 2'd1 && pop)) begin
                    buf0_next = fifo_dout;
                end else begin
                    buf1_next = fifo_dout;
                end
            end
            case ({inflight_reg, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    // State registers; clearing inflight on flush discards the word still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= 2'd0;
            inflight_reg <= 1'b0;
            buf0_reg     <= '0;
            buf1_reg     <= '0;
            valid_reg    <= 1'b0;
        end else begin
            count_reg    <= count_next;
            inflight_reg <= fifo_rd_en;
            buf0_reg     <= buf0_next;
            buf1_reg     <= buf1_next;
            valid_reg    <= (count_next != 2'd0);
        end
    end

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [COUNT_WIDTH-1:0] beats_reg;

    assign beats_count = beats_reg;

    // Saturating count of accepted words. A flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_reg <= '0;
        end else if (pop && beats_reg != {COUNT_WIDTH{1'b1}}) begin
            beats_reg <= beats_reg + 1'b1;
        end
    end
`endif

endmodule
